fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of the `fifo` block between N_REQ producers. Each producer offers a word with a valid/ready handshake. The arbiter registers the winning word onto the FIFO `wr`/`data_in` pins and tracks FIFO occupancy with a local counter, so it never issues a write the FIFO would drop. It sits between the producer agents and the `fifo` instance, alongside the existing `full`/`empty` flags.

## Interface
- `DATA_WIDTH`, 8, width of one FIFO word
- `N_REQ`, 4, number of producers (2..8)
- `DEPTH`, 16, FIFO capacity in words; must match the `fifo` instance
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  N_REQ  producer i offers a word
- `req_data`  in  N_REQ*DATA_WIDTH  producer i word at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready`  out  N_REQ  one-hot-or-zero grant, combinational
- `wr`  out  1  registered FIFO write strobe
- `data_in`  out  DATA_WIDTH  registered FIFO write data
- `rd`  in  1  FIFO read strobe, observed only
- `full`  in  1  FIFO full flag, safety interlock
- `credits`  out  $clog2(DEPTH+1)  free slots: DEPTH − occupancy − wr

## Operation
- **Occupancy counter `occ`**, width $clog2(DEPTH+1):
  - +1 on an edge with `wr`=1.
  - −1 on an edge with `rd`=1 and `occ`>0.
  - Both events on the same edge leave `occ` unchanged.
  - `rd` with `occ`=0 is ignored, matching the FIFO's read-on-empty behaviour.
- **Space condition:** `space` = (`occ` + `wr` < DEPTH) && !`full`. The in-flight `wr` is counted, so back-to-back writes run at full rate until the last slot.
- **Grant:** when `space`=1, `req_ready` is one-hot on the first requester with `req_valid`=1, searching from `last`+1 modulo N_REQ.
- **Grant pointer `last`:** resets to N_REQ−1, so requester 0 has first priority. It updates to the granted index on each accept.
- **Accept** (`req_valid[i]` && `req_ready[i]` at an edge): `wr`<=1 and `data_in`<=`req_data[i]`. With no accept, `wr`<=0 and `data_in` holds its value.
- **Producer obligation:** a producer holds `req_valid` and its data stable until it is granted. The arbiter never grants a requester whose valid is low.
- **No space:** `req_ready`=0 and no pointer change.

## Timing
- Reset values: `wr`=0, `data_in`=0, `occ`=0, `last`=N_REQ−1, `credits`=DEPTH, stats counters=0.
- `req_ready` and `credits` are combinational from registered state plus `req_valid` and `full`; there is no combinational path from `req_data`.
- Latency from accept edge to FIFO write edge is exactly 1 cycle.
- Throughput is one word per cycle while `occ` + `wr` < DEPTH.
- With `occ`=DEPTH−1 and `wr`=1, `req_ready` is 0 that cycle.
- Reset asserted mid-stream clears all state immediately. An in-flight `wr` is dropped, and the FIFO is reset by the same `rst`.

## Configuration
- **`FIFO_ARB_STATS_EN` defined:** adds output `grant_cnt` (N_REQ×16 bits, producer i at `[i*16 +: 16]`).
  - Counts accepts per producer.
  - Saturates at 16'hFFFF and clears on `rst`.
- **Not defined:** the port and counters are absent. Arbitration behaviour is identical either way.

## Structure
- Package `fifo_arb_pkg` holds:
  - defaults `FIFO_ARB_DATA_W`=8, `FIFO_ARB_N_REQ`=4, `FIFO_ARB_DEPTH`=16, `FIFO_ARB_STAT_W`=16;
  - function `rr_pick(valid, last)` returning the grant index.
- Sub-module `rr_arbiter` (parameter N) holds the pointer register and the one-hot grant logic. It takes `clk`, `rst`, `valid`, `enable` (= `space`) and `advance` (= accept), and outputs `grant`.
- The top level holds `occ`, the output registers and the optional stats.

## Test plan
1. Reset; all `req_valid`=0 -> `wr`=0, `credits`=16, `req_ready`=0.
2. All four producers valid continuously, `rd`=0 -> grants in order 0,1,2,3,0,1,…; 16 writes on consecutive cycles, then `req_ready`=0 with `occ`=16, `credits`=0.
3. From full, pulse `rd` for one cycle -> next grant after one cycle goes to the next requester in round-robin order; `occ` returns to 16.
4. `rd` and `wr` on the same edge at `occ`=5 -> `occ` stays 5; `rd` at `occ`=0 with `wr`=0 -> `occ` stays 0.
5. Only producer 2 valid with data 8'hA5 -> `wr`=1 and `data_in`=8'hA5 one cycle after the accept; `last`=2.
6. Assert `rst` with `wr`=1 and `occ`=9 -> `wr`=0, `occ`=0, `credits`=16 before the next edge. With `FIFO_ARB_STATS_EN` defined, all `grant_cnt` fields read 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and the round-robin pick function for the FIFO write arbiter.
// Used by rr_arbiter and fifo_wr_arbiter (import fifo_arb_pkg::*).
package fifo_arb_pkg;

  localparam int FIFO_ARB_DATA_W = 8;
  localparam int FIFO_ARB_N_REQ  = 4;
  localparam int FIFO_ARB_DEPTH  = 16;
  localparam int FIFO_ARB_STAT_W = 16;
  localparam int FIFO_ARB_MAX_N  = 8;

  // Index of the first set bit of valid, searching from last+1 mod n.
  // Returns last when nothing is valid; callers gate with |valid.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] valid,
    input logic [2:0] last,
    input int         n
  );
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= FIFO_ARB_MAX_N; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: pointer register plus one-hot grant logic.
// Ports: clk, rst, valid[N], enable, advance -> grant[N] (one-hot or zero).
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N = FIFO_ARB_N_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] valid,
  input  logic         enable,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last;
  logic [7:0]    valid_w;
  logic [2:0]    pick;

  always_comb begin
    valid_w         = '0;
    valid_w[N-1:0]  = valid;
  end

  assign pick = rr_pick(valid_w, 3'(last), N);

  always_comb begin
    grant = '0;
    if (enable && |valid)
      grant[pick[IW-1:0]] = 1'b1;
  end

  // Reset to N-1 so requester 0 wins the first search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= IW'(N - 1);
    else if (advance)
      last <= pick[IW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the shared FIFO write port, with local
// occupancy tracking. Ports: clk, rst, req_valid/req_data/req_ready,
// wr/data_in (registered), rd/full (observed), credits (free slots).
// Optional FIFO_ARB_STATS_EN adds grant_cnt (16-bit saturating per producer).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_ARB_DATA_W,
  parameter int N_REQ      = FIFO_ARB_N_REQ,
  parameter int DEPTH      = FIFO_ARB_DEPTH,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        wr,
  output logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        rd,
  input  logic                        full,
  output logic [CW-1:0]               credits
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*FIFO_ARB_STAT_W-1:0] grant_cnt
`endif
);

  localparam int SW = FIFO_ARB_STAT_W;

  logic [CW-1:0]         occ;
  logic [CW:0]           fill;
  logic                  space;
  logic                  accept;
  logic                  rd_eff;
  logic [DATA_WIDTH-1:0] sel_data;

  // The in-flight write counts as occupied so the last slot is never
  // handed out twice.
  assign fill    = {1'b0, occ} + (CW+1)'(wr);
  assign space   = (fill < (CW+1)'(DEPTH)) && !full;
  assign credits = CW'(DEPTH) - occ - CW'(wr);
  assign accept  = |(req_valid & req_ready);
  assign rd_eff  = rd && (occ != '0);

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .enable (space),
    .advance(accept),
    .grant  (req_ready)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i])
        sel_data |= req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ     <= '0;
      wr      <= 1'b0;
      data_in <= '0;
    end else begin
      case ({wr, rd_eff})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      wr <= accept;
      if (accept)
        data_in <= sel_data;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i] &&
            grant_cnt[i*SW +: SW] != {SW{1'b1}})
          grant_cnt[i*SW +: SW] <= grant_cnt[i*SW +: SW] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed
// corner sequences, and randomized traffic against a reference model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int D  = 16;
  localparam int CW = 5;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr;
  logic [DW-1:0]   data_in;
  logic            rd;
  logic            full;
  logic [CW-1:0]   credits;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .N_REQ     (N),
    .DEPTH     (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .wr       (wr),
    .data_in  (data_in),
    .rd       (rd),
    .full     (full),
    .credits  (credits)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: occupancy as an integer, grant by scanning
  // producers in round-robin order after the last winner.
  int       m_occ;
  int       m_last;
  bit       m_wr;
  bit [7:0] m_data;

  task automatic m_reset();
    m_occ  = 0;
    m_last = N - 1;
    m_wr   = 0;
    m_data = 0;
  endtask

  function automatic int m_grant();
    int idx;
    if (!((m_occ + int'(m_wr)) < D) || full)
      return -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (req_valid[idx])
        return idx;
    end
    return -1;
  endfunction

  task automatic m_edge(input int g);
    if (rd && m_occ > 0)
      m_occ = m_occ - 1;
    if (m_wr)
      m_occ = m_occ + 1;
    if (g >= 0) begin
      m_wr   = 1;
      m_data = req_data[g*DW +: DW];
      m_last = g;
    end else begin
      m_wr = 0;
    end
  endtask

  task automatic m_check(input int g);
    chk("rand_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
    chk("rand_credits", int'(credits), D - m_occ - int'(m_wr));
    chk("rand_wr", int'(wr), int'(m_wr));
    chk("rand_data", int'(data_in), int'(m_data));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rd        = 1'b0;
    full      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic          rd;
    logic          full;
    logic [N-1:0]  ready;
    logic [CW-1:0] credits;
    logic          wr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int g;
    vecs[0] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 5'd16, 1'b0};
    vecs[1] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 5'd16, 1'b0};
    vecs[2] = '{4'b1111, 1'b0, 1'b0, 4'b0010, 5'd15, 1'b1};
    vecs[3] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 5'd14, 1'b1};
    vecs[4] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 5'd14, 1'b0};
    vecs[5] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 5'd13, 1'b1};
    vecs[6] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 5'd14, 1'b0};
    vecs[7] = '{4'b0011, 1'b0, 1'b0, 4'b0010, 5'd13, 1'b1};

    // Reset state and vector table
    do_reset();
    #1;
    chk("reset_wr", int'(wr), 0);
    chk("reset_data", int'(data_in), 0);
    chk("reset_credits", int'(credits), 16);
    chk("reset_ready", int'(req_ready), 0);
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].valid;
      rd        = vecs[i].rd;
      full      = vecs[i].full;
      #1;
      chk($sformatf("vec%0d_ready", i), int'(req_ready), int'(vecs[i].ready));
      chk($sformatf("vec%0d_credits", i), int'(credits), int'(vecs[i].credits));
      chk($sformatf("vec%0d_wr", i), int'(wr), int'(vecs[i].wr));
      tick();
    end

    // Fill from empty with all producers valid
    do_reset();
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("fill_ready", int'(req_ready), 1 << (k % 4));
      chk("fill_credits", int'(credits), 16 - k);
      if (k > 0)
        chk("fill_data", int'(data_in), 8'h11 * ((k - 1) % 4 + 1));
      tick();
    end
    #1;
    chk("fill_last_ready", int'(req_ready), 0);
    chk("fill_last_credits", int'(credits), 0);
    chk("fill_last_wr", int'(wr), 1);
    tick();
    #1;
    chk("full_ready", int'(req_ready), 0);
    chk("full_credits", int'(credits), 0);
    chk("full_wr", int'(wr), 0);

    // One read from full frees one slot; producer 0 is next in order
    rd = 1'b1;
    #1;
    chk("rdpulse_ready", int'(req_ready), 0);
    tick();
    rd = 1'b0;
    #1;
    chk("refill_ready", int'(req_ready), 4'b0001);
    chk("refill_credits", int'(credits), 1);
    tick();
    #1;
    chk("refill_wr", int'(wr), 1);
    chk("refill_credits2", int'(credits), 0);
    chk("refill_ready2", int'(req_ready), 0);
    tick();
    #1;
    chk("refull_credits", int'(credits), 0);
    chk("refull_wr", int'(wr), 0);

    // Read on empty ignored; read and write on same edge cancel
    do_reset();
    rd = 1'b1;
    #1;
    tick();
    rd = 1'b0;
    #1;
    chk("rd_empty_credits", int'(credits), 16);
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) tick();
    req_valid = 4'b0000;
    tick();
    #1;
    chk("occ5_credits", int'(credits), 11);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    rd = 1'b1;
    #1;
    chk("rdwr_pre_credits", int'(credits), 10);
    tick();
    rd = 1'b0;
    #1;
    chk("rdwr_credits", int'(credits), 11);
    chk("rdwr_wr", int'(wr), 0);

    // Single producer 2, then pointer check
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    #1;
    chk("p2_ready", int'(req_ready), 4'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("p2_wr", int'(wr), 1);
    chk("p2_data", int'(data_in), 8'hA5);
    req_valid = 4'b1111;
    #1;
    chk("p2_next_ready", int'(req_ready), 4'b1000);
    tick();

    // Asynchronous reset mid-stream
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000005A;
    for (int k = 0; k < 10; k++) tick();
    req_valid = 4'b0000;
    #1;
    chk("pre_rst_credits", int'(credits), 6);
    chk("pre_rst_wr", int'(wr), 1);
`ifdef FIFO_ARB_STATS_EN
    chk("pre_rst_cnt0", int'(grant_cnt[15:0]), 10);
`endif
    rst = 1'b1;
    #1;
    chk("rst_wr", int'(wr), 0);
    chk("rst_credits", int'(credits), 16);
    chk("rst_data", int'(data_in), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("rst_cnt", (grant_cnt == '0) ? 1 : 0, 1);
`endif
    @(negedge clk);
    rst = 1'b0;
    m_reset();

    // Randomized traffic; producers hold valid/data until granted
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          req_valid[i]          = 1'($urandom_range(0, 1));
          req_data[i*DW +: DW]  = 8'($urandom);
        end
      end
      rd   = ($urandom_range(0, 99) < (((c / 300) % 2) ? 60 : 15));
      full = ($urandom_range(0, 19) == 0);
      #1;
      g = m_grant();
      m_check(g);
      @(posedge clk);
      m_edge(g);
      @(negedge clk);
      if (g >= 0)
        req_valid[g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
